// File: rtl/mac_result_sink_if.sv
// mac_result_sink_if: result handshake from the MAC engine plus the
// lane stream toward writeback, bundled for the mac_result_sink block.
// The slave modport is the sink's view; master is the driver/consumer view.
interface mac_result_sink_if;
    logic [1:0]   mode;
    logic         valid;
    logic         ready;
    logic [127:0] sum_in;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_lane;
    logic         out_last;

    modport slave (
        input  mode,
        input  valid,
        input  sum_in,
        input  out_ready,
        output ready,
        output out_data,
        output out_valid,
        output out_lane,
        output out_last
    );

    modport master (
        output mode,
        output valid,
        output sum_in,
        output out_ready,
        input  ready,
        input  out_data,
        input  out_valid,
        input  out_lane,
        input  out_last
    );
endinterface

// File: rtl/mac_result_sink.sv
// mac_result_sink: captures one packed 128-bit MAC result with its precision
// mode, then streams the signed lanes for that mode one per cycle.
// Optional feature: define MAC_SINK_SAT_EN to clamp each lane to the signed
// 16-bit range before sign-extension to 32 bits.
module mac_result_sink (
    input  logic                     clk,
    input  logic                     nrst,
    mac_result_sink_if.slave         bus,
    output logic                     err_mode,
    output logic [15:0]              results_rcvd
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [1:0] MODE_2B  = 2'b00;
    localparam logic [1:0] MODE_4B  = 2'b01;
    localparam logic [1:0] MODE_8B  = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    logic [0:0]   state;
    logic [127:0] hold;
    logic [1:0]   mode_q;
    logic [3:0]   lane_cnt;
    logic [3:0]   last_lane;
    logic [6:0]   base;
    logic [31:0]  lane_ext;
    logic [31:0]  lane_out;
    logic         draining;
    logic         lane_done;

    assign draining  = (state == ST_DRAIN);
    assign lane_done = draining && bus.out_ready;

    // Index of the final lane for the latched precision mode.
    always_comb begin
        last_lane = 4'd0;
        case (mode_q)
            MODE_2B: last_lane = 4'd15;
            MODE_4B: last_lane = 4'd3;
            default: last_lane = 4'd0;
        endcase
    end

    // Extract the current lane from the hold register and sign-extend it.
    always_comb begin
        base     = 7'd0;
        lane_ext = 32'd0;
        case (mode_q)
            MODE_2B: begin
                base     = 7'(lane_cnt) * 7'd8;
                lane_ext = {{24{hold[base + 7'd7]}}, hold[base +: 8]};
            end
            MODE_4B: begin
                base     = 7'(lane_cnt) * 7'd12;
                lane_ext = {{20{hold[base + 7'd11]}}, hold[base +: 12]};
            end
            default: begin
                lane_ext = {{12{hold[19]}}, hold[19:0]};
            end
        endcase
    end

`ifdef MAC_SINK_SAT_EN
    // Clamp the sign-extended lane into the signed 16-bit range.
    always_comb begin
        lane_out = lane_ext;
        if ($signed(lane_ext) > 32'sd32767) begin
            lane_out = 32'h0000_7FFF;
        end else if ($signed(lane_ext) < -32'sd32768) begin
            lane_out = 32'hFFFF_8000;
        end
    end
`else
    // Plain sign-extension, lanes pass straight through.
    always_comb begin
        lane_out = lane_ext;
    end
`endif

    assign bus.ready     = (state == ST_IDLE);
    assign bus.out_valid = draining;
    assign bus.out_data  = draining ? lane_out : 32'd0;
    assign bus.out_lane  = lane_cnt;
    assign bus.out_last  = draining && (lane_cnt == last_lane);

    // Capture results in IDLE and walk the lane counter while draining.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            hold         <= 128'd0;
            mode_q       <= MODE_2B;
            lane_cnt     <= 4'd0;
            err_mode     <= 1'b0;
            results_rcvd <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        hold         <= bus.sum_in;
                        mode_q       <= bus.mode;
                        lane_cnt     <= 4'd0;
                        results_rcvd <= results_rcvd + 16'd1;
                        if (bus.mode == MODE_BAD) begin
                            err_mode <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                default: begin
                    if (lane_done) begin
                        if (lane_cnt == last_lane) begin
                            state <= ST_IDLE;
                        end else begin
                            lane_cnt <= lane_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/mac_result_sink.md
# mac_result_sink

Receiving end of the MAC engine's valid/ready result interface. Accepts one packed 128-bit accumulated sum per handshake and latches the precision mode with it. Unpacks the sum into signed lanes for that mode and streams them one per cycle on a 32-bit output with its own valid/ready. Sits between the MAC engine's output buffer and the downstream writeback path.

## Interface
- No parameters; lane geometry is fixed by mode.
- `clk` input 1: single clock, all state on rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `mode` input 2: precision mode sampled at capture. 00 = 2bx2b, 01 = 4bx4b, 10 = 8bx8b, 11 = illegal.
- `valid` input 1: MAC engine has a result on `sum_in`; held until accepted.
- `ready` output 1: sink can accept; high only in IDLE.
- `sum_in` input 128: packed accumulated result.
- `out_data` output 32: current lane, sign-extended (saturated when configured).
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: downstream accepts lane.
- `out_lane` output 4: index of current lane.
- `out_last` output 1: current lane is last of the result.
- `err_mode` output 1: sticky; set when a result is captured with mode 11.
- `results_rcvd` output 16: count of accepted results, wraps at 0xFFFF→0.

## Operation
- States: IDLE, DRAIN.
- IDLE: `ready`=1, `out_valid`=0.
  - On `valid && ready`: capture `sum_in` into a 128-bit hold register, latch `mode`, clear the lane counter, increment `results_rcvd`.
  - For mode 00/01/10, go to DRAIN.
  - For mode 11, set `err_mode`, stay in IDLE and emit no lanes.
- DRAIN: `ready`=0, `out_valid`=1.
  - On `out_valid && out_ready`: if counter == lastlane, go to IDLE; otherwise increment the counter.
- Lane map by latched mode, lane i:
  - 10: 1 lane, bits [19:0], 20-bit signed, lastlane = 0.
  - 01: 4 lanes, bits [12i+11:12i], 12-bit signed, lastlane = 3.
  - 00: 16 lanes, bits [8i+7:8i], 8-bit signed, lastlane = 15.
  - Unused upper hold bits are ignored.
- Output fields:
  - `out_data` = selected lane sign-extended to 32 bits.
  - `out_lane` = counter.
  - `out_last` = (counter == lastlane) while `out_valid`, else 0.
- `mode` changes after capture have no effect until the next capture.
- `err_mode` clears only on reset.

## Timing
- Reset values: `ready`=1 (IDLE), `out_valid`=0, `out_data`=0, `out_lane`=0, `out_last`=0, `err_mode`=0, `results_rcvd`=0, hold register = 0.
- Reset mid-DRAIN aborts the result immediately: remaining lanes are dropped and the block is in IDLE after reset.
- `ready` is decoded from state only; no combinational path from `valid`.
- Capture edge N → `out_valid`=1 from cycle N+1 with lane 0.
- Each accepted lane advances one cycle. With `out_ready` held high, a k-lane result drains in k cycles and `ready` returns the cycle after the last lane is accepted.
- Minimum result-to-result spacing is k+1 cycles.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_lane` and `out_last` hold stable.
- `valid` during DRAIN is not accepted; the MAC engine holds it until IDLE.

## Configuration
- `MAC_SINK_SAT_EN` defined: each lane is clamped to signed 16-bit range [-32768, 32767] before sign-extension to 32 bits. This only affects 8bx8b lanes, since narrower lanes always fit.
- Undefined: plain sign-extension, no clamp logic.

## Test plan
- Reset then 8bx8b: `sum_in[19:0]`=20'hFFF38, `out_ready`=1. One lane: `out_data`=32'hFFFFFF38, `out_lane`=0, `out_last`=1; `results_rcvd`=1; `ready` high 2 cycles after capture.
- 4bx4b with lanes 12'h7FF, 12'h800, 12'h001, 12'h000. Outputs 32'h000007FF, 32'hFFFFF800, 32'h00000001, 32'h0; `out_last` only on lane 3.
- 2bx2b with byte i = i−8 for i=0..15. 16 lanes with values −8..7 sign-extended, `out_lane` 0..15, `out_last` on 15. `valid` held during drain is not accepted until IDLE.
- Backpressure: 4bx4b, `out_ready` low for 3 cycles on lane 1. Lane 1 data and index hold, no lane skipped or duplicated, 4 lanes total.
- Saturation, 8bx8b, `sum_in[19:0]`=20'h7FFFF:
  - With `MAC_SINK_SAT_EN`: output 32'h00007FFF.
  - Without: output 32'h0007FFFF.
  - 20'h80000 with the macro: output 32'hFFFF8000.
- Mode 11 capture: `err_mode`=1, no `out_valid`, `ready` stays high. Then assert `nrst` low mid-DRAIN of a 2bx2b result: all outputs return to reset values asynchronously.
